// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Shares one instruction-memory port between CPU fetch and a
//               byte-stream program loader; holds the CPU in reset while
//               loading. Optional IMEM_CLEAR_EN zero-fills memory first.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] c_run  = 2'd0;
`ifdef IMEM_CLEAR_EN
  localparam logic [1:0] c_clear = 2'd1;
`endif
  localparam logic [1:0] c_load = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]      r_state;
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W:0] r_len;
  logic            r_err;
  logic            w_len_ok;
  logic            w_hs;
  logic            w_last;

  assign w_len_ok = (load_len != '0) && (load_len <= c_depth);
  // Abort has priority over a byte offered in the same cycle.
  assign w_hs     = (r_state == c_load) && s_valid && !load_abort;
  assign w_last   = (r_cnt == (r_len - c_one));
  assign err      = r_err;

  always_comb begin
    s_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = s_data;
    mem_addr  = r_cnt[ADDR_W-1:0];
    cpu_instr = '0;
    cpu_rst   = 1'b1;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      c_run: begin
        mem_addr  = cpu_pc;
        cpu_instr = mem_rdata;
        cpu_rst   = 1'b0;
        busy      = 1'b0;
      end
`ifdef IMEM_CLEAR_EN
      c_clear: begin
        mem_we    = !load_abort;
        mem_wdata = '0;
      end
`endif
      c_load: begin
        s_ready = !load_abort;
        mem_we  = w_hs;
      end
      c_done: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_run;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_run: begin
          if (load_req) begin
            if (w_len_ok) begin
              r_len <= load_len;
              r_cnt <= '0;
              r_err <= 1'b0;
`ifdef IMEM_CLEAR_EN
              r_state <= c_clear;
`else
              r_state <= c_load;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
`ifdef IMEM_CLEAR_EN
        c_clear: begin
          if (load_abort) begin
            r_state <= c_run;
            r_err   <= 1'b1;
          end else if (r_cnt[ADDR_W-1:0] == '1) begin
            r_cnt   <= '0;
            r_state <= c_load;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
`endif
        c_load: begin
          if (load_abort) begin
            r_state <= c_run;
            r_err   <= 1'b1;
          end else if (w_hs) begin
            r_cnt <= r_cnt + c_one;
            if (w_last) begin
              r_state <= c_done;
            end
          end
        end
        c_done: begin
          r_state <= c_run;
        end
        default: begin
          r_state <= c_run;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// Testbench for imem_load_ctrl: memory model plus a list-based reference of
// expected writes and memory image, driven with randomized byte streams.
module tb_imem_load_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_req = 1'b0;
  logic [8:0] load_len = '0;
  logic       load_abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic [7:0] cpu_pc = '0;
  logic [7:0] cpu_instr;
  logic       cpu_rst;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       err;

  imem_load_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
    .load_abort(load_abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_rst(cpu_rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read, bench-side fill port.
  logic [7:0] mem [256];
  logic       fill = 1'b0;
  logic [7:0] fill_addr = '0;
  logic [7:0] fill_data = '0;
  always @(posedge clk) begin
    if (fill) mem[fill_addr] <= fill_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  logic [15:0] wq[$];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (done) done_cnt <= done_cnt + 1;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] bytes_a [256];

  task automatic fetch_check(input int n);
    for (int k = 0; k < n; k++) begin
      cpu_pc = 8'($urandom);
      #1;
      checks++;
      if (cpu_instr !== ref_mem[cpu_pc]) begin
        errors++;
        $display("FAIL fetch pc=%h got %h exp %h", cpu_pc, cpu_instr, ref_mem[cpu_pc]);
      end
      checks++;
      if (mem_we !== 1'b0 || cpu_rst !== 1'b0) begin
        errors++;
        $display("FAIL run_outputs we=%b cpu_rst=%b exp 0 0", mem_we, cpu_rst);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_load(input int len, input int idle_pct, input bit gap1, input int abort_idx);
    int w0, d0, idx, cyc, n;
    bit hs, aborted, gapped;
    logic [15:0] exp_q[$];
    w0 = wq.size(); d0 = done_cnt;
    load_req = 1'b1; load_len = 9'(len);
    @(negedge clk);
    load_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL load_start busy=%b cpu_rst=%b err=%b exp 1 1 0", busy, cpu_rst, err);
    end
    idx = 0; cyc = 0; aborted = 0; gapped = 0;
    while (idx < len && !aborted && cyc < 3000) begin
      hs = 0;
      s_data = bytes_a[idx];
      if (idx == abort_idx) begin
        s_valid = 1'b1; load_abort = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL abort_block s_ready=%b we=%b exp 0 0", s_ready, mem_we);
        end
        aborted = 1;
      end else begin
        if ((gap1 && idx == 1 && !gapped) || ($urandom % 100) < idle_pct) begin
          s_valid = 1'b0; gapped = 1;
        end else begin
          s_valid = 1'b1;
        end
        #1;
        hs = s_valid && s_ready;
      end
      @(negedge clk);
      if (hs) idx++;
      cyc++;
    end
    s_valid = 1'b0; load_abort = 1'b0;
    #1;
    if (aborted) begin
      n = abort_idx;
      checks++;
      if (busy !== 1'b0 || cpu_rst !== 1'b0 || err !== 1'b1 || done_cnt !== d0) begin
        errors++;
        $display("FAIL abort_end busy=%b cpu_rst=%b err=%b dones=%0d exp 0 0 1 0",
                 busy, cpu_rst, err, done_cnt - d0);
      end
    end else begin
      n = len;
      checks++;
      if (idx != len || done !== 1'b1 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse bytes=%0d done=%b busy=%b cpu_rst=%b exp %0d 1 1 1",
                 idx, done, busy, cpu_rst, len);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b0 || done_cnt !== d0 + 1) begin
        errors++;
        $display("FAIL release done=%b busy=%b cpu_rst=%b dones=%0d exp 0 0 0 1",
                 done, busy, cpu_rst, done_cnt - d0);
      end
    end
`ifdef IMEM_CLEAR_EN
    for (int a = 0; a < 256; a++) begin
      exp_q.push_back({8'(a), 8'h00});
      ref_mem[a] = 8'h00;
    end
`endif
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), bytes_a[i]});
      ref_mem[i] = bytes_a[i];
    end
    checks++;
    if (wq.size() - w0 != exp_q.size()) begin
      errors++;
      $display("FAIL write_count got %0d exp %0d", wq.size() - w0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && w0 + i < wq.size(); i++) begin
      checks++;
      if (wq[w0 + i] !== exp_q[i]) begin
        errors++;
        $display("FAIL write[%0d] got addr/data %h exp %h", i, wq[w0 + i], exp_q[i]);
      end
    end
    @(negedge clk);
    fetch_check(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fill = 1'b1; fill_addr = 8'(i);
      fill_data = (i == 5) ? 8'hA5 : 8'($urandom);
      ref_mem[i] = fill_data;
      @(negedge clk);
    end
    fill = 1'b0;
    cpu_pc = 8'h05;
    #1;
    checks++;
    if (cpu_instr !== 8'hA5 || cpu_rst !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 ||
        err !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset instr=%h cpu_rst=%b busy=%b rdy=%b err=%b we=%b done=%b exp a5 0 0 0 0 0 0",
               cpu_instr, cpu_rst, busy, s_ready, err, mem_we, done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_instr !== 8'hA5 || mem_addr !== 8'h05) begin
      errors++;
      $display("FAIL run_fetch instr=%h addr=%h exp a5 05", cpu_instr, mem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_gap_load();
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33;
    run_load(3, 0, 1'b1, -1);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 256; i++) bytes_a[i] = 8'($urandom);
    run_load(256, 0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    int w0;
    logic [8:0] lens [3];
    lens[0] = 9'd0; lens[1] = 9'd257; lens[2] = 9'(257 + $urandom_range(0, 254));
    w0 = wq.size();
    for (int k = 0; k < 3; k++) begin
      load_req = 1'b1; load_len = lens[k];
      @(negedge clk);
      load_req = 1'b0;
      #1;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0 || wq.size() != w0) begin
        errors++;
        $display("FAIL illegal_len=%0d err=%b busy=%b cpu_rst=%b writes=%0d exp 1 0 0 0",
                 lens[k], err, busy, cpu_rst, wq.size() - w0);
      end
      @(negedge clk);
    end
    bytes_a[0] = 8'($urandom); bytes_a[1] = 8'($urandom);
    run_load(2, 20, 1'b0, -1);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) bytes_a[i] = 8'($urandom);
    run_load(4, 0, 1'b0, 2);
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 4; r++) begin
      int len;
      len = (r == 0) ? 1 : $urandom_range(1, 256);
      for (int i = 0; i < 256; i++) bytes_a[i] = 8'($urandom);
      run_load(len, 30, 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_load();
    load_req = 1'b1; load_len = 9'd100;
    @(negedge clk);
    load_req = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || cpu_rst !== 1'b0 || s_ready !== 1'b0 || mem_we !== 1'b0 ||
        err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%b cpu_rst=%b rdy=%b we=%b err=%b done=%b exp all 0",
               busy, cpu_rst, s_ready, mem_we, err, done);
    end
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || cpu_rst !== 1'b0 || mem_addr !== cpu_pc) begin
      errors++;
      $display("FAIL post_reset busy=%b cpu_rst=%b addr=%h exp 0 0 %h", busy, cpu_rst, mem_addr, cpu_pc);
    end
  endtask

  initial begin
    test_reset();
    test_gap_load();
    test_full_load();
    test_illegal();
    test_abort();
    test_random_loads();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
